bus_arbiter: RTL and testbench

//  Registered, arbitrated shared bus: COUNT sources of WIDTH bits request the bus.
//  A round-robin arbiter picks one owner per cycle and drives its data onto a registered output.

---
 rtl/bus_arbiter.sv | 94 +++++++++
 tb/tb_bus_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Registered round-robin arbiter for a shared bus with hold/lock and contention reporting.
// Optional saturating contention counter enabled by defining BUS_CONFLICT_CNT_EN.
//
// state | meaning
// IDLE  | no owner, out = IDLE_VALUE, grant = 0
// OWNED | source `owner` drives out, grant[owner] = 1
module bus_arbiter #(
  parameter int                 WIDTH      = 8,
  parameter int                 COUNT      = 4,
  parameter logic [WIDTH-1:0]   IDLE_VALUE = '0
) (
  input  logic                    clk_25mhz,
  input  logic                    rst_n,
  input  logic [WIDTH*COUNT-1:0]  in,
  input  logic [COUNT-1:0]        req,
  input  logic [COUNT-1:0]        hold,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic [COUNT-1:0]        grant,
  output logic                    conflict,
  output logic [15:0]             conflict_count
);

  localparam int PW = (COUNT > 1) ? $clog2(COUNT) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick;
  logic            found;
  logic            stay;
  logic            any_req;
  logic            multi;

  always_comb begin
    stay    = (state == OWNED) && req[owner] && hold[owner];
    any_req = |req;
    multi   = $countones(req) > 1;
    pick    = '0;
    found   = 1'b0;
    // Scan from ptr upward with wrap so a lone requester always wins.
    for (int j = 0; j < COUNT; j++) begin
      int idx;
      idx = (int'(ptr) + j) % COUNT;
      if (!found && req[idx]) begin
        pick  = PW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25mhz) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      grant     <= '0;
      out       <= IDLE_VALUE;
      out_valid <= 1'b0;
      conflict  <= 1'b0;
    end else if (stay) begin
      out      <= in[owner*WIDTH +: WIDTH];
      conflict <= 1'b0;
    end else if (any_req) begin
      state     <= OWNED;
      owner     <= pick;
      grant     <= COUNT'(1) << pick;
      out       <= in[pick*WIDTH +: WIDTH];
      out_valid <= 1'b1;
      conflict  <= multi;
      ptr       <= (pick == PW'(COUNT-1)) ? '0 : pick + 1'b1;
    end else begin
      state     <= IDLE;
      grant     <= '0;
      out       <= IDLE_VALUE;
      out_valid <= 1'b0;
      conflict  <= 1'b0;
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  always_ff @(posedge clk_25mhz) begin
    if (!rst_n)
      conflict_count <= '0;
    else if (!stay && multi && conflict_count != 16'hFFFF)
      conflict_count <= conflict_count + 16'd1;
  end
`else
  assign conflict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural ownership/pointer model.
module tb_bus_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        rst_n;
  logic [31:0] in;
  logic [3:0]  req, hold;
  logic [7:0]  out;
  logic        out_valid;
  logic [3:0]  grant;
  logic        conflict;
  logic [15:0] conflict_count;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] PAT = {8'h66, 8'haa, 8'h55, 8'h99};

`ifdef BUS_CONFLICT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  bus_arbiter #(.WIDTH(8), .COUNT(4), .IDLE_VALUE(8'h00)) dut (
    .clk_25mhz      (clk_25mhz),
    .rst_n          (rst_n),
    .in             (in),
    .req            (req),
    .hold           (hold),
    .out            (out),
    .out_valid      (out_valid),
    .grant          (grant),
    .conflict       (conflict),
    .conflict_count (conflict_count)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // reference model: owner index (-1 = idle), round-robin pointer, expected outputs
  int          m_own;
  int          m_ptr;
  logic [7:0]  m_out;
  logic        m_conf;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int nreq;
    nreq = 0;
    for (int i = 0; i < 4; i++) if (req[i]) nreq++;
    if (!rst_n) begin
      m_own = -1; m_ptr = 0; m_out = 8'h00; m_conf = 0; m_cnt = 0;
    end else if (m_own >= 0 && req[m_own] && hold[m_own]) begin
      m_out  = in[m_own*8 +: 8];
      m_conf = 0;
    end else if (nreq > 0) begin
      for (int j = 0; j < 4; j++) begin
        int i;
        i = (m_ptr + j) % 4;
        if (req[i]) begin
          m_own = i;
          break;
        end
      end
      m_ptr  = (m_own + 1) % 4;
      m_out  = in[m_own*8 +: 8];
      m_conf = (nreq > 1);
      if (m_conf && CNT_EN && m_cnt < 65535) m_cnt++;
    end else begin
      m_own = -1; m_out = 8'h00; m_conf = 0;
    end
  endtask

  task automatic check_all();
    chk("out",       {24'h0, out},            {24'h0, m_out});
    chk("out_valid", {31'h0, out_valid},      {31'h0, (m_own >= 0)});
    chk("grant",     {28'h0, grant},          (m_own >= 0) ? (32'h1 << m_own) : 32'h0);
    chk("conflict",  {31'h0, conflict},       {31'h0, m_conf});
    chk("count",     {16'h0, conflict_count}, m_cnt);
  endtask

  task automatic cycle(input logic rv, input logic [3:0] r, input logic [3:0] h,
                       input logic [31:0] d, input bit do_chk);
    @(negedge clk_25mhz);
    rst_n = rv; req = r; hold = h; in = d;
    @(posedge clk_25mhz);
    model_step();
    #1;
    if (do_chk) check_all();
  endtask

  initial begin
    logic [3:0] exp_g [5];
    logic [7:0] exp_o [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_o = '{8'h99, 8'h55, 8'haa, 8'h66, 8'h99};
    m_own = -1; m_ptr = 0; m_out = 0; m_conf = 0; m_cnt = 0;
    rst_n = 1'b0; req = 4'hF; hold = 4'h0; in = PAT;

    // reset wins over requests
    repeat (2) begin
      cycle(1'b0, 4'hF, 4'h0, PAT, 1);
      chk("rst_grant", {28'h0, grant}, 32'h0);
      chk("rst_out",   {24'h0, out},   32'h0);
    end

    // single requester after reset
    cycle(1'b1, 4'b0100, 4'h0, PAT, 1);
    chk("single_grant", {28'h0, grant}, 32'h4);
    chk("single_out",   {24'h0, out},   32'haa);

    // full contention rotation
    cycle(1'b0, 4'h0, 4'h0, PAT, 1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 4'hF, 4'h0, PAT, 1);
      chk("rr_grant", {28'h0, grant},    {28'h0, exp_g[k]});
      chk("rr_out",   {24'h0, out},      {24'h0, exp_o[k]});
      chk("rr_conf",  {31'h0, conflict}, 32'h1);
    end
    chk("rr_count", {16'h0, conflict_count}, CNT_EN ? 32'd5 : 32'd0);

    // hold lock on src1, then release by dropping req[1]
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 4'hF, 4'b0010, PAT, 1);
      chk("hold_grant", {28'h0, grant}, 32'h2);
      chk("hold_out",   {24'h0, out},   32'h55);
    end
    chk("hold_conf", {31'h0, conflict}, 32'h0);
    cycle(1'b1, 4'b1101, 4'b0010, PAT, 1);
    chk("release_grant", {28'h0, grant}, 32'h4);

    // idle keeps pointer
    cycle(1'b0, 4'h0, 4'h0, PAT, 1);
    cycle(1'b1, 4'b0001, 4'h0, PAT, 1);
    chk("idle_a_out", {24'h0, out}, 32'h99);
    cycle(1'b1, 4'b0000, 4'h0, PAT, 1);
    chk("idle_b_out",   {24'h0, out},       32'h00);
    chk("idle_b_valid", {31'h0, out_valid}, 32'h0);
    cycle(1'b1, 4'hF, 4'h0, PAT, 1);
    chk("ptr_kept_grant", {28'h0, grant}, 32'h2);

    // randomized traffic with occasional mid-operation reset
    for (int k = 0; k < 400; k++) begin
      logic rv;
      rv = ($urandom_range(0, 39) != 0);
      cycle(rv, 4'($urandom), 4'($urandom), $urandom, 1);
    end

`ifdef BUS_CONFLICT_CNT_EN
    // counter saturation
    cycle(1'b0, 4'h0, 4'h0, PAT, 1);
    for (int k = 0; k < 65534; k++) cycle(1'b1, 4'b0011, 4'h0, PAT, 0);
    check_all();
    chk("sat_fffe", {16'h0, conflict_count}, 32'hFFFE);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4'b0011, 4'h0, PAT, 1);
    chk("sat_ffff", {16'h0, conflict_count}, 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
